pattern_rom_player: RTL and testbench

PATTERN_ROM_PLAYER -- requirements
Module: pattern_rom_player

---
 rtl/pattern_rom_player.sv | 168 ++++++++++++++++
 tb/tb_pattern_rom_player.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_rom_player.sv
// Fixed-pattern ROM with a registered random-access read port and a streaming
// playback engine that walks an address range up or down, one-shot or looping.
module pattern_rom_player #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = DATA_WIDTH + 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  start,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic                  stop,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int PAT_W = 4 * ((DATA_WIDTH + 3) / 4);
  localparam logic [DATA_WIDTH-1:0] ONE_LSB = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ALT_HI  = {(DATA_WIDTH/2){2'b10}};
  localparam logic [DATA_WIDTH-1:0] ALT_LO  = {(DATA_WIDTH/2){2'b01}};
  localparam logic [PAT_W-1:0]      PAT_1001 = {(PAT_W/4){4'b1001}};
  // Keep the MSB-aligned part when the width is not a multiple of four.
  localparam logic [DATA_WIDTH-1:0] NIB_PAT = PAT_1001[PAT_W-1 -: DATA_WIDTH];

  function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] addr);
    int                    idx;
    logic [DATA_WIDTH-1:0] w;
    idx = int'(addr);
    w   = '0;
    if (idx >= DEPTH) begin
      w = '0;
    end else if (idx < DATA_WIDTH) begin
      w = ONE_LSB << idx;
    end else if (idx == DATA_WIDTH) begin
      w = ALT_HI;
    end else if (idx == DATA_WIDTH + 1) begin
      w = ALT_LO;
    end else if (idx == DATA_WIDTH + 2) begin
      w = NIB_PAT;
    end else begin
      w = '0;
    end
    return w;
  endfunction

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] first_q;
  logic [ADDR_WIDTH-1:0] last_q;
  logic                  loop_q;
  logic                  down_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  at_last_d;
  logic [ADDR_WIDTH-1:0] ptr_d;
  logic [DATA_WIDTH-1:0] word_d;

  // Random-access read port, independent of playback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rom_word(rd_addr);
      end
    end
  end

  // Next playback address: wrap to the first bound after the last one so loop
  // mode keeps one word per cycle across the wrap.
  always_comb begin
    at_last_d = (ptr_q == last_q);
    ptr_d     = ptr_q;
    if (at_last_d) begin
      ptr_d = first_q;
    end else if (down_q) begin
      ptr_d = ptr_q - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end
    word_d = rom_word(ptr_d);
  end

  // Playback FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      loop_q      <= 1'b0;
      down_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            first_q     <= first_addr;
            last_q      <= last_addr;
            loop_q      <= loop;
            down_q      <= (first_addr > last_addr);
            ptr_q       <= first_addr;
            out_data_q  <= rom_word(first_addr);
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (stop) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (out_ready) begin
            if (at_last_d && !loop_q) begin
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end else begin
              ptr_q      <= ptr_d;
              out_data_q <= word_d;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_rom_player.sv
// Scoreboard bench for pattern_rom_player: stimulus pushes expected words,
// a negedge monitor pops and compares read and playback outputs.
module tb_pattern_rom_player;

  logic       clk;
  logic       rst_n;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       start;
  logic       loop;
  logic [3:0] first_addr;
  logic [3:0] last_addr;
  logic       stop;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       done;

  logic        rd2_en;
  logic [4:0]  rd2_addr;
  logic [15:0] rd2_data;
  logic        rd2_valid;
  logic [15:0] out2_data;
  logic        out2_valid;
  logic        busy2;
  logic        done2;

  int checks;
  int failures;

  logic [7:0]  rd_q[$];
  logic [15:0] rd2_q[$];
  logic [7:0]  play_q[$];

  pattern_rom_player u_dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .start(start), .loop(loop),
    .first_addr(first_addr), .last_addr(last_addr), .stop(stop),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  pattern_rom_player #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd2_en), .rd_addr(rd2_addr),
    .rd_data(rd2_data), .rd_valid(rd2_valid), .start(1'b0), .loop(1'b0),
    .first_addr(5'd0), .last_addr(5'd0), .stop(1'b0),
    .out_ready(1'b0), .out_data(out2_data), .out_valid(out2_valid),
    .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_play(input logic [3:0] f, input logic [3:0] l, input logic lp);
    first_addr = f;
    last_addr  = l;
    loop       = lp;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_busy"},  {31'd0, busy},      32'd0);
    chk({name, "_done"},  {31'd0, done},      32'd0);
  endtask

  task automatic chk_done(input string name);
    chk({name, "_q_empty"}, play_q.size(), 32'd0);
    chk({name, "_done"},    {31'd0, done},  32'd1);
    chk({name, "_busy"},    {31'd0, busy},  32'd0);
    chk({name, "_valid"},   {31'd0, out_valid}, 32'd0);
    tick();
    chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  // Monitor: compares every read result and every accepted playback word.
  initial begin
    logic       held_v;
    logic [7:0] held_d;
    held_v = 1'b0;
    held_d = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rd_data", {24'd0, rd_data}, {24'd0, rd_q.pop_front()});
      end
      if (rd2_valid) begin
        if (rd2_q.size() == 0) chk("rd16_unexpected", 32'd1, 32'd0);
        else chk("rd16_data", {16'd0, rd2_data}, {16'd0, rd2_q.pop_front()});
      end
      if (out_valid) begin
        if (held_v) chk("hold_stable", {24'd0, out_data}, {24'd0, held_d});
        if (out_ready) begin
          if (play_q.size() == 0) chk("play_unexpected", 32'd1, 32'd0);
          else chk("play_data", {24'd0, out_data}, {24'd0, play_q.pop_front()});
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_d = out_data;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rom8 [16];
    checks = 0;
    failures = 0;
    rom8 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
             8'hAA, 8'h55, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst_n = 1'b0; rd_en = 1'b0; rd_addr = 4'd0; start = 1'b0; loop = 1'b0;
    first_addr = 4'd0; last_addr = 4'd0; stop = 1'b0; out_ready = 1'b0;
    rd2_en = 1'b0; rd2_addr = 5'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_data",  {24'd0, rd_data},  32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk_idle("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back random reads over the full address space
    for (int a = 0; a < 16; a++) begin
      rd_en = 1'b1;
      rd_addr = 4'(a);
      rd_q.push_back(rom8[a]);
      tick();
    end
    rd_addr = 4'd8;
    rd_q.push_back(8'hAA);
    tick();
    rd_en = 1'b0;
    tick();
    tick();
    chk("rd_idle_valid", {31'd0, rd_valid}, 32'd0);
    chk("rd_hold_data",  {24'd0, rd_data},  32'h0000_00AA);

    // Wide instance ROM contents
    for (int a = 15; a < 32; a++) begin
      rd2_en = 1'b1;
      rd2_addr = 5'(a);
      if (a == 15)      rd2_q.push_back(16'h8000);
      else if (a == 16) rd2_q.push_back(16'hAAAA);
      else if (a == 17) rd2_q.push_back(16'h5555);
      else if (a == 18) rd2_q.push_back(16'h9999);
      else              rd2_q.push_back(16'h0000);
      tick();
    end
    rd2_en = 1'b0;
    tick();
    tick();

    // One-shot ascending 2..5
    out_ready = 1'b1;
    play_q.push_back(8'h04); play_q.push_back(8'h08);
    play_q.push_back(8'h10); play_q.push_back(8'h20);
    start_play(4'd2, 4'd5, 1'b0);
    chk("asc_busy", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    chk_done("asc");

    // Descending loop 10..8 with toggling backpressure; a start mid-stream is ignored
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      play_q.push_back(8'h99); play_q.push_back(8'h55); play_q.push_back(8'hAA);
    end
    play_q.push_back(8'h99);
    start_play(4'd10, 4'd8, 1'b1);
    for (int i = 0; i < 60; i++) begin
      if (play_q.size() == 0) break;
      out_ready = ~out_ready;
      if (i == 3) begin
        start = 1'b1; first_addr = 4'd0; last_addr = 4'd0; loop = 1'b0;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("bp_drained", play_q.size(), 32'd0);
    out_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("bp_stop");

    // Loop wrap 3..4 with no bubbles
    out_ready = 1'b1;
    play_q.push_back(8'h08); play_q.push_back(8'h10); play_q.push_back(8'h08);
    play_q.push_back(8'h10); play_q.push_back(8'h08);
    start_play(4'd3, 4'd4, 1'b1);
    repeat (5) tick();
    chk("wrap_nobubble", play_q.size(), 32'd0);
    out_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("wrap_stop");

    // Stop during the third word of a 0..7 loop, then restart
    out_ready = 1'b1;
    play_q.push_back(8'h01); play_q.push_back(8'h02); play_q.push_back(8'h04);
    start_play(4'd0, 4'd7, 1'b1);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("stop");
    chk("stop_last_counted", play_q.size(), 32'd0);
    tick();
    play_q.push_back(8'h01); play_q.push_back(8'h02); play_q.push_back(8'h04);
    start_play(4'd0, 4'd7, 1'b1);
    chk("restart_data", {24'd0, out_data}, 32'h0000_0001);
    repeat (3) tick();
    out_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("restart_stop");

    // Out-of-range bounds play zeros, descending one-shot
    out_ready = 1'b1;
    play_q.push_back(8'h00); play_q.push_back(8'h00);
    start_play(4'd13, 4'd12, 1'b0);
    repeat (2) tick();
    chk_done("oor");

    // Reset in the middle of playback and reads, then an immediate start
    out_ready = 1'b0;
    first_addr = 4'd0; last_addr = 4'd7; loop = 1'b1; start = 1'b1;
    rd_en = 1'b1; rd_addr = 4'd3;
    rd_q.push_back(8'h08);
    tick();
    start = 1'b0;
    rd_q.push_back(8'h08);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_rd_data",  {24'd0, rd_data},  32'd0);
    chk("mrst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("mrst_out_data", {24'd0, out_data}, 32'd0);
    chk_idle("mrst");
    rst_n = 1'b1;
    rd_en = 1'b0;
    out_ready = 1'b1;
    play_q.push_back(8'h04);
    start_play(4'd2, 4'd2, 1'b0);
    chk("mrst_restart_busy", {31'd0, busy}, 32'd1);
    tick();
    chk_done("single");

    tick();
    chk("rd_q_empty",   rd_q.size(),   32'd0);
    chk("rd16_q_empty", rd2_q.size(),  32'd0);
    chk("play_q_empty", play_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
